// File: rtl/hawk_rd_pkg.sv
// Shared types and line/slot helpers for the HAWK metadata table-read engine.
// Consumers cast rsp_entry_o through AttEntry or ListEntry.
package hawk_rd_pkg;

   typedef enum logic {
      TBL_ATT = 1'b0,
      TBL_LST = 1'b1
   } tbl_sel_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_AR,
      ST_R,
      ST_RSP
   } rd_eng_state_e;

   localparam int unsigned LINE_BYTES_LOG2 = 6;

   typedef logic [63:0]  AttEntry;
   typedef logic [127:0] ListEntry;

   // Entries per line is a power of two, so line/slot reduce to shift and mask.
   function automatic logic [31:0] line_of(input logic [31:0] idx, input int unsigned epl);
      return idx >> $clog2(epl);
   endfunction

   function automatic logic [31:0] slot_of(input logic [31:0] idx, input int unsigned epl);
      return idx & (epl - 1);
   endfunction

endpackage

// File: rtl/hawk_rr_arb.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last winner.
module hawk_rr_arb #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid
);

   logic [IDX_W-1:0] ptr;

   always_comb begin
      logic [IDX_W-1:0] cand;
      // NOTE: every output gets a default before the search so no path holds an old value (no latch).
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
         if (en && req[cand] && !gnt_valid) begin
            gnt_valid = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr <= '0;
      end else if (gnt_valid) begin
         ptr <= IDX_W'((32'(gnt_idx) + 1) % NUM_REQ);
      end
   end

endmodule

// File: rtl/hawk_tbl_rd_eng.sv
// Arbitrated ATT/list entry reader: ID -> cache-line AXI read -> extracted entry,
// with a one-line reuse buffer per table.
module hawk_tbl_rd_eng
   import hawk_rd_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned AXI_ADDR_W  = 64,
   parameter int unsigned AXI_DATA_W  = 512,
   parameter int unsigned ID_W        = 20,
   parameter int unsigned ATT_ENTRY_W = 64,
   parameter int unsigned LST_ENTRY_W = 128,
   parameter logic [AXI_ADDR_W-1:0] ATT_BASE = '0,
   parameter logic [AXI_ADDR_W-1:0] LST_BASE = '0,
   parameter int unsigned ATT_MAX     = 4096,
   parameter int unsigned LST_MAX     = 4096
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic [NUM_REQ-1:0]         req_tbl_i,
   input  logic [NUM_REQ*ID_W-1:0]    req_id_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [$clog2(NUM_REQ)-1:0] rsp_req_o,
   output logic [LST_ENTRY_W-1:0]     rsp_entry_o,
   output logic                       rsp_err_o,
   input  logic                       inval_i,
   output logic [AXI_ADDR_W-1:0]      araddr_o,
   output logic                       arvalid_o,
   input  logic                       arready_i,
   output logic [7:0]                 arlen_o,
   output logic [2:0]                 arsize_o,
   input  logic [AXI_DATA_W-1:0]      rdata_i,
   input  logic [1:0]                 rresp_i,
   input  logic                       rlast_i,
   input  logic                       rvalid_i,
   output logic                       rready_o
);

   localparam int unsigned EPL_ATT = AXI_DATA_W / ATT_ENTRY_W;
   localparam int unsigned EPL_LST = AXI_DATA_W / LST_ENTRY_W;
   localparam int unsigned REQ_W   = $clog2(NUM_REQ);

   rd_eng_state_e          state;
   logic [REQ_W-1:0]       cur_req;
   tbl_sel_e               cur_tbl;
   logic [ID_W-1:0]        cur_id;
   logic                   inval_seen;
   logic [1:0]             buf_valid;
   logic [ID_W-1:0]        buf_tag  [2];
   logic [AXI_DATA_W-1:0]  buf_data [2];

   logic [REQ_W-1:0]       gnt_idx;
   logic                   gnt_valid;
   logic [ID_W-1:0]        idx, line, slot;
   logic [AXI_ADDR_W-1:0]  line_addr;
   logic                   id_bad, hit, load_en;
   logic [AXI_DATA_W-1:0]  src_line;
   logic [LST_ENTRY_W-1:0] entry;
   logic                   unused_rlast;

   assign arlen_o      = 8'd0;
   assign arsize_o     = 3'd6;
   assign unused_rlast = rlast_i;

   hawk_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(REQ_W)) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en        (state == ST_IDLE),
      .req       (req_valid_i),
      .gnt       (req_ready_o),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always_comb begin
      idx = cur_id - ID_W'(1);
      if (cur_tbl == TBL_LST) begin
         line      = ID_W'(line_of(32'(idx), EPL_LST));
         slot      = ID_W'(slot_of(32'(idx), EPL_LST));
         line_addr = LST_BASE + (AXI_ADDR_W'(line) << LINE_BYTES_LOG2);
         id_bad    = (cur_id == '0) || (32'(cur_id) > LST_MAX);
      end else begin
         line      = ID_W'(line_of(32'(idx), EPL_ATT));
         slot      = ID_W'(slot_of(32'(idx), EPL_ATT));
         line_addr = ATT_BASE + (AXI_ADDR_W'(line) << LINE_BYTES_LOG2);
         id_bad    = (cur_id == '0) || (32'(cur_id) > ATT_MAX);
      end
      hit = buf_valid[cur_tbl] && (buf_tag[cur_tbl] == line) && !inval_i;
   end

   // The R beat supplies the line on a miss; the reuse buffer supplies it on a hit.
   always_comb begin
      src_line = (state == ST_R) ? rdata_i : buf_data[cur_tbl];
      if (cur_tbl == TBL_LST)
         entry = LST_ENTRY_W'(src_line >> (32'(slot) * LST_ENTRY_W));
      else
         entry = LST_ENTRY_W'(ATT_ENTRY_W'(src_line >> (32'(slot) * ATT_ENTRY_W)));
   end

   assign load_en = (state == ST_R) && rvalid_i && (rresp_i == 2'b00) && !inval_seen && !inval_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         cur_req     <= '0;
         cur_tbl     <= TBL_ATT;
         cur_id      <= '0;
         inval_seen  <= 1'b0;
         buf_valid   <= '0;
         araddr_o    <= '0;
         arvalid_o   <= 1'b0;
         rready_o    <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_req_o   <= '0;
         rsp_entry_o <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         if (inval_i)      buf_valid          <= '0;
         else if (load_en) buf_valid[cur_tbl] <= 1'b1;
         if (inval_i)      inval_seen         <= 1'b1;

         case (state)
            ST_IDLE: if (gnt_valid) begin
               cur_req   <= gnt_idx;
               rsp_req_o <= gnt_idx;
               cur_tbl   <= tbl_sel_e'(req_tbl_i[gnt_idx]);
               cur_id    <= ID_W'(req_id_i >> (32'(gnt_idx) * ID_W));
               state     <= ST_CHECK;
            end
            ST_CHECK: begin
               inval_seen <= 1'b0;
               if (id_bad || hit) begin
                  rsp_err_o   <= id_bad;
                  rsp_entry_o <= id_bad ? '0 : entry;
                  rsp_valid_o <= 1'b1;
                  state       <= ST_RSP;
               end else begin
                  araddr_o  <= line_addr;
                  arvalid_o <= 1'b1;
                  state     <= ST_AR;
               end
            end
            ST_AR: if (arready_i) begin
               arvalid_o <= 1'b0;
               rready_o  <= 1'b1;
               state     <= ST_R;
            end
            ST_R: if (rvalid_i) begin
               rready_o    <= 1'b0;
               rsp_err_o   <= (rresp_i != 2'b00);
               rsp_entry_o <= (rresp_i != 2'b00) ? '0 : entry;
               rsp_valid_o <= 1'b1;
               state       <= ST_RSP;
            end
            ST_RSP: if (rsp_ready_i) begin
               rsp_valid_o <= 1'b0;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: line data and tags are left unreset; buf_valid alone decides whether they are meaningful.
   always_ff @(posedge clk_i) begin
      if (load_en) begin
         buf_data[cur_tbl] <= rdata_i;
         buf_tag[cur_tbl]  <= line;
      end
   end

endmodule

// File: doc/hawk_tbl_rd_eng.md
Name: hawk_tbl_rd_eng

Overview:
- Sequential, parametrised table-read engine for HAWK metadata tables: ATT entries (tbl=0) and list entries (tbl=1).
- Replaces the one-shot address/decode helper functions with an arbitrated request engine. It converts a 1-based entry ID into a cache-line AXI read, extracts the addressed entry and returns it to the requester.
- Keeps a one-line reuse buffer per table, so repeated hits on the same line skip AXI traffic.
- Sits between the page-read manager / compression manager (requesters) and the AXI read channel.

Parameters:
- NUM_REQ, 2, number of requesters, round-robin arbitrated.
- AXI_ADDR_W, 64, AXI address width.
- AXI_DATA_W, 512, line width in bits; one beat equals one 64-byte line.
- ID_W, 20, entry-ID width.
- ATT_ENTRY_W, 64, ATT entry bits; entries per line EPL_ATT=AXI_DATA_W/ATT_ENTRY_W, which must be a power of 2.
- LST_ENTRY_W, 128, list entry bits; EPL_LST=AXI_DATA_W/LST_ENTRY_W, which must be a power of 2.
- ATT_BASE, 'h0, ATT table byte base (64 B aligned).
- LST_BASE, 'h0, list table byte base (64 B aligned).
- ATT_MAX, 'd4096, largest legal ATT ID.
- LST_MAX, 'd4096, largest legal list ID.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_tbl_i  in  NUM_REQ  table select per requester: 0=ATT, 1=LST
- req_id_i  in  NUM_REQ*ID_W  1-based entry IDs, packed
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_req_o  out  clog2(NUM_REQ)  index of the requester being answered
- rsp_entry_o  out  LST_ENTRY_W  extracted entry; ATT entries are zero-extended
- rsp_err_o  out  1  illegal ID or AXI error
- inval_i  in  1  invalidate both line buffers (table writer updated memory)
- araddr_o  out  AXI_ADDR_W  read address
- arvalid_o  out  1
- arready_i  in  1
- arlen_o  out  8  constant 0
- arsize_o  out  3  constant 3'd6
- rdata_i  in  AXI_DATA_W
- rresp_i  in  2
- rlast_i  in  1
- rvalid_i  in  1
- rready_o  out  1

Behaviour:
- Reset values: all outputs 0 except the constant arlen_o and arsize_o. Both buffer valid bits are 0, the round-robin pointer is 0, and the FSM is in IDLE.
- FSM states: IDLE, CHECK, AR, R, RSP.
- IDLE: arbitrate round-robin among asserted req_valid_i, starting after the last granted index. Pulse req_ready_o for one cycle for the winner and latch its tbl/id. Go to CHECK.
- CHECK (one cycle):
  - idx = id-1; line = idx / EPL; slot = idx % EPL.
  - addr = BASE + (line << 6), computed at AXI_ADDR_W with no truncation.
  - If id==0 or id>MAX: set err, go to RSP; no AXI traffic.
  - If the buffer for tbl is valid, its tag equals line, and inval_i is low: hit, go to RSP.
  - Otherwise go to AR.
- AR: hold arvalid_o and araddr_o stable until arready_i. Go to R.
- R: rready_o=1. On the rvalid_i beat:
  - rresp_i != 0: set err; the buffer is not updated.
  - Otherwise: extract rdata_i[slot*ENTRY_W +: ENTRY_W]. Load the buffer (data, tag, valid=1) unless inval_i was seen at any point since AR issue.
  - Go to RSP. rlast_i is ignored (single beat).
- RSP: rsp_valid_o held with stable payload until rsp_ready_i, then go to IDLE. No new grant occurs in the cycle rsp_ready_i is accepted.
- Latency from req_ready_o pulse (edge N):
  - hit or err: rsp_valid_o high from N+2;
  - miss: arvalid_o high from N+2; rsp_valid_o high 1 cycle after the R beat.
- inval_i clears both valids in any state. If inval_i and a buffer load occur in the same cycle, invalidation wins.
- Only one transaction is in flight at a time; AXI has no outstanding reads beyond one.
- An asynchronous reset mid-transaction drops all state. System reset must also reset the AXI slave.

Decomposition:
- Shared package hawk_rd_pkg:
  - tbl_sel_e enum (TBL_ATT, TBL_LST);
  - rd_eng_state_e;
  - the line-address/slot functions, parametrised by EPL;
  - the AttEntry and ListEntry typedefs, used by consumers to cast rsp_entry_o.
- Sub-module hawk_rr_arb (NUM_REQ round-robin arbiter, one-hot grant, pointer update on grant).

Test Plan:
- Reset: rst_ni low mid-AR → arvalid_o=0, rsp_valid_o=0, and valids cleared. Next ATT id=1 misses, with araddr=ATT_BASE.
- ATT miss then hit: id=10 → araddr=ATT_BASE+'h40, rsp_entry = rdata[127:64]. Then id=16 → no AR, rsp at N+2 with rdata[511:448].
- LST extraction: id=5 → araddr=LST_BASE+'h40, entry rdata[127:0]. Then id=8 → hit, rdata[511:384].
- Errors: id=0 → rsp_err=1 with no AR. id=ATT_MAX+1 → err. rresp=2'b10 → err, and the repeat of the same id re-issues AR.
- Arbitration: both requesters valid continuously → grants alternate 0,1,0,1, and rsp_req_o matches each grant.
- Invalidate: inval_i pulsed during R → response still returned. The same-line request afterwards misses and issues AR again. rsp_ready_i held low for 5 cycles → payload stable.
